// File: rtl/hex_display_sequencer.sv
// Serial word capture plus a scan sequencer that shows the committed word one nibble at a
// time on a single 7-segment digit, most-significant nibble first, with optional blanking.
module hex_display_sequencer #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned DWELL_CYCLES = 1024,
    parameter int unsigned BLANK_CYCLES = 16,
    localparam int unsigned NIB   = DATA_BITS / 4,
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             load,
    input  logic             hold,
    output logic [6:0]       seg,
    output logic             dp,
    output logic [IDX_W-1:0] nib_idx,
    output logic             word_ready,
    output logic             load_err
);

    localparam int unsigned MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned DW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int unsigned CW      = $clog2(DATA_BITS + 1);

    localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [DW-1:0]    BLANK_LAST = DW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CW-1:0]    CNT_FULL   = CW'(DATA_BITS);
    localparam logic [IDX_W-1:0] NIB_LAST   = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {StIdle, StShow, StBlank} state_e;

    state_e                 state;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   disp_reg;
    logic [CW-1:0]          bit_cnt;
    logic [DW-1:0]          dwell;
    logic [DATA_BITS-1:0]   disp_shifted;
    logic [3:0]             cur_nib;
    logic [IDX_W-1:0]       nib_next;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign word_ready = (bit_cnt == CNT_FULL);

    // Index 0 selects the most-significant nibble.
    always_comb begin
        disp_shifted = disp_reg << (4 * nib_idx);
        cur_nib      = disp_shifted[DATA_BITS-1 -: 4];
        nib_next     = (nib_idx == NIB_LAST) ? '0 : nib_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            disp_reg <= '0;
            state    <= StIdle;
            nib_idx  <= '0;
            dwell    <= '0;
            seg      <= '0;
            dp       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            load_err <= 1'b0;
            if (ser_valid) begin
                shreg <= {shreg[DATA_BITS-2:0], ser_in};
            end

            if (load && word_ready) begin
                // Commit the pre-shift word; a same-cycle bit starts the next word.
                disp_reg <= shreg;
                bit_cnt  <= ser_valid ? CW'(1) : '0;
                state    <= StShow;
                nib_idx  <= '0;
                dwell    <= '0;
            end else begin
                if (load) begin
                    load_err <= 1'b1;
                end
                if (ser_valid && !word_ready) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (!hold) begin
                    unique case (state)
                        StShow: begin
                            if (dwell == DWELL_LAST) begin
                                dwell <= '0;
                                if (BLANK_CYCLES == 0) begin
                                    nib_idx <= nib_next;
                                end else begin
                                    state <= StBlank;
                                end
                            end else begin
                                dwell <= dwell + 1'b1;
                            end
                        end
                        StBlank: begin
                            if (dwell == BLANK_LAST) begin
                                dwell   <= '0;
                                state   <= StShow;
                                nib_idx <= nib_next;
                            end else begin
                                dwell <= dwell + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            seg <= (state == StShow) ? hex7(cur_nib) : 7'h00;
            dp  <= (state == StShow) && (nib_idx == '0);
        end
    end

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Bench for hex_display_sequencer: a blanking build and a no-blank build share stimulus and are
// checked against a time-since-load scan model.
module tb_hex_display_sequencer;

    localparam int unsigned DB    = 8;
    localparam int unsigned DWELL = 4;
    localparam int unsigned BLANK = 2;
    localparam int unsigned NIB   = DB / 4;

    logic       clk = 1'b0;
    logic       reset, ser_in, ser_valid, load, hold;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, nib_a, nib_b, wr_a, wr_b, err_a, err_b;

    always #5 clk = ~clk;

    hex_display_sequencer #(
        .DATA_BITS(DB), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)
    ) u_dut (
        .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid), .load(load),
        .hold(hold), .seg(seg_a), .dp(dp_a), .nib_idx(nib_a), .word_ready(wr_a),
        .load_err(err_a)
    );

    hex_display_sequencer #(
        .DATA_BITS(DB), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(0)
    ) u_dut_noblank (
        .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid), .load(load),
        .hold(hold), .seg(seg_b), .dp(dp_b), .nib_idx(nib_b), .word_ready(wr_b),
        .load_err(err_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: the scan is just elapsed un-held cycles since the last accepted load.
    bit         m_active;
    int         m_t;
    int         m_cnt;
    logic [7:0] m_disp, m_shreg;

    function automatic int cur_n(input int blank);
        int p = DWELL + blank;
        return (m_t % (NIB * p)) / p;
    endfunction

    function automatic bit showing(input int blank);
        int p = DWELL + blank;
        return m_active && ((m_t % p) < DWELL);
    endfunction

    function automatic logic [6:0] exp_seg(input int blank);
        logic [3:0] nb;
        if (!showing(blank)) return 7'h00;
        nb = 4'(m_disp >> (4 * (NIB - 1 - cur_n(blank))));
        return hex_tab[nb];
    endfunction

    function automatic logic exp_dp(input int blank);
        return showing(blank) && (cur_n(blank) == 0);
    endfunction

    task automatic cyc(input logic sv, input logic si, input logic ld, input logic hd,
                       input logic rs);
        logic [6:0] sa, sb;
        logic       pa, pb, e_err;
        reset = rs; ser_valid = sv; ser_in = si; load = ld; hold = hd;
        sa = exp_seg(BLANK); sb = exp_seg(0);
        pa = exp_dp(BLANK);  pb = exp_dp(0);
        e_err = 1'b0;
        @(posedge clk);
        #1;
        if (rs) begin
            m_active = 0; m_t = 0; m_cnt = 0; m_disp = '0; m_shreg = '0;
            sa = '0; sb = '0; pa = 0; pb = 0;
        end else begin
            if (ld && m_cnt == DB) begin
                m_disp   = m_shreg;
                m_cnt    = sv ? 1 : 0;
                m_active = 1;
                m_t      = 0;
            end else begin
                e_err = ld;
                if (sv && m_cnt < DB) m_cnt++;
                if (m_active && !hd) m_t++;
            end
            if (sv) m_shreg = {m_shreg[6:0], si};
        end
        check_val("seg", 32'(seg_a), 32'(sa));
        check_val("dp", 32'(dp_a), 32'(pa));
        check_val("nib_idx", 32'(nib_a), m_active ? 32'(cur_n(BLANK)) : 32'd0);
        check_val("word_ready", 32'(wr_a), 32'(m_cnt == DB));
        check_val("load_err", 32'(err_a), 32'(e_err));
        check_val("nb_seg", 32'(seg_b), 32'(sb));
        check_val("nb_dp", 32'(dp_b), 32'(pb));
        check_val("nb_nib_idx", 32'(nib_b), m_active ? 32'(cur_n(0)) : 32'd0);
        check_val("nb_word_ready", 32'(wr_b), 32'(m_cnt == DB));
        check_val("nb_load_err", 32'(err_b), 32'(e_err));
    endtask

    task automatic shift_bits(input logic [7:0] w, input int from, input int to);
        for (int i = from; i <= to; i++) cyc(1'b1, w[7-i], 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; load = 1'b0; hold = 1'b0;
        m_active = 0; m_t = 0; m_cnt = 0; m_disp = '0; m_shreg = '0;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 1);
        repeat (20) cyc(0, 0, 0, 0, 0);

        // Early load is rejected, then the completed 0xA5 is accepted.
        shift_bits(8'hA5, 0, 4);
        cyc(0, 0, 1, 0, 0);
        shift_bits(8'hA5, 5, 7);
        cyc(0, 0, 1, 0, 0);
        repeat (7) cyc(0, 0, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 1, 0);
        repeat (20) cyc(0, 0, 0, 0, 0);

        // Mid-scan load of 0x3C with a same-cycle shift bit.
        shift_bits(8'h3C, 0, 7);
        cyc(1, 1, 1, 0, 0);
        shift_bits(8'($urandom), 1, 7);
        for (int i = 0; i < 24; i++) begin
            if (m_active && (m_t % (DWELL + BLANK)) >= DWELL) break;
            cyc(0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 1);
        repeat (10) cyc(0, 0, 0, 0, 0);

        shift_bits(8'h5A, 0, 7);
        cyc(0, 0, 1, 0, 0);
        repeat (20) cyc(0, 0, 0, 0, 0);

        repeat (3000) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 299) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
